// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, clock glitch filter, 11-bit frame decoder
// with start/odd-parity/stop checks and inter-edge timeout, feeding a first-word-fall-through FIFO.
module ps2_rx_fifo #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 8000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       CLK_40MHZ,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] SCAN_CODE,
  output logic       SCAN_VALID,
  input  logic       SCAN_READY,
  output logic       FRAME_ERR,
  output logic       OVERFLOW
);

  localparam int unsigned FCntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TCntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_t;

  // Input synchronisers and clock filter
  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic             clk_f_q, clk_f_d, clk_f_prev_q;
  logic [FCntW-1:0] fcnt_q, fcnt_d;
  logic             fall;

  always_ff @(posedge CLK_40MHZ or posedge RESET) begin
    if (RESET) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      clk_f_q      <= 1'b1;
      clk_f_prev_q <= 1'b1;
      fcnt_q       <= '0;
    end else begin
      clk_s1_q     <= PS2_CLK;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= PS2_DATA;
      dat_s2_q     <= dat_s1_q;
      clk_f_q      <= clk_f_d;
      clk_f_prev_q <= clk_f_q;
      fcnt_q       <= fcnt_d;
    end
  end

  // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples
  always_comb begin
    clk_f_d = clk_f_q;
    fcnt_d  = '0;
    if (clk_s2_q != clk_f_q) begin
      if (fcnt_q == FCntW'(FILTER_LEN - 1)) begin
        clk_f_d = ~clk_f_q;
      end else begin
        fcnt_d = fcnt_q + FCntW'(1);
      end
    end
  end

  assign fall = clk_f_prev_q & ~clk_f_q;

  // Frame decoder
  state_t           state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [TCntW-1:0] tcnt_q, tcnt_d;
  logic             push_q, push_d;
  logic [7:0]       push_data_q, push_data_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge CLK_40MHZ or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tcnt_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      tcnt_q      <= tcnt_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    ferr_d      = 1'b0;
    tcnt_d      = tcnt_q + TCntW'(1);
    if (fall || (state_q == StIdle)) begin
      tcnt_d = '0;
    end
    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!dat_s2_q) begin
            state_d  = StData;
            bitcnt_d = '0;
          end
        end
        StData: begin
          shreg_d  = {dat_s2_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          par_d   = dat_s2_q;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (dat_s2_q && (^{shreg_q, par_q})) begin
            push_d      = 1'b1;
            push_data_d = shreg_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if ((state_q != StIdle) && (tcnt_q == TCntW'(TIMEOUT_CYCLES - 1))) begin
      // Edge arriving on the expiry cycle takes priority (handled above)
      state_d = StIdle;
      ferr_d  = 1'b1;
      tcnt_d  = '0;
    end
  end

  // Scan-code FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          empty, full, pop, do_push, ovf_d, ovf_q;
  logic [7:0]    scan_code_q, scan_code_d;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = ~empty & SCAN_READY;
  assign do_push = push_q & (~full | pop);
  assign ovf_d   = push_q & full & ~pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(do_push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    scan_code_d = scan_code_q;
    if (do_push || pop) begin
      // New head may be the byte being written this very cycle
      if (do_push && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
        scan_code_d = push_data_q;
      end else begin
        scan_code_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge CLK_40MHZ) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_q;
    end
  end

  always_ff @(posedge CLK_40MHZ or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      scan_code_q <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      scan_code_q <= scan_code_d;
      ovf_q       <= ovf_d;
    end
  end

  assign SCAN_CODE  = scan_code_q;
  assign SCAN_VALID = ~empty;
  assign FRAME_ERR  = ferr_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: clean frames, bad parity, timeout, glitch filter,
// FIFO overflow / simultaneous push-pop, and reset mid-frame.
module tb_ps2_rx_fifo;

  // Short PS/2 half-period keeps the run small; still far above the filter length
  // and far below the inter-edge timeout.
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] code;
  logic       valid, ferr, ovf;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  int long_cnt = 0;
  logic ferr_prev = 1'b0;
  logic ovf_prev = 1'b0;

  always #5 clk = ~clk;

  ps2_rx_fifo dut (
    .CLK_40MHZ (clk),
    .RESET     (rst),
    .PS2_CLK   (ps2_clk),
    .PS2_DATA  (ps2_data),
    .SCAN_CODE (code),
    .SCAN_VALID(valid),
    .SCAN_READY(ready),
    .FRAME_ERR (ferr),
    .OVERFLOW  (ovf)
  );

  always @(negedge clk) begin
    if (ferr) ferr_cnt++;
    if (ovf) ovf_cnt++;
    if ((ferr && ferr_prev) || (ovf && ovf_prev)) long_cnt++;
    ferr_prev = ferr;
    ovf_prev  = ovf;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal;
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(s);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid); end
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL rst_code got %h want 00", code); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b want 0", ferr); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", ovf); end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b want 0", valid); end
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL post_rst_code got %h want 00", code); end
  endtask

  task automatic test_basic;
    logic [7:0] d;
    int f0;
    d  = 8'h1C;
    f0 = ferr_cnt;
    // Ready while empty must be ignored
    @(negedge clk); ready = 1'b1;
    repeat (5) @(negedge clk); ready = 1'b0;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    // 2 sync + 8 filter edges to the fall strobe, push next, valid the cycle after
    repeat (11) @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got %b want 0", valid); end
    @(posedge clk);
    #1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid_rise got %b want 1", valid); end
    checks++; if (code !== 8'h1C) begin errors++; $display("FAIL basic_code got %h want 1c", code); end
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid_hold got %b want 1", valid); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL basic_ferr got %0d want 0", ferr_cnt - f0); end
    @(negedge clk); ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %b want 0", valid); end
    @(negedge clk); ready = 1'b0;
  endtask

  task automatic test_parity_err;
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL par_ferr got %0d want 1", ferr_cnt - f0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL par_valid got %b want 0", valid); end
    send_frame(8'hF0, 1'b1, 1'b1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL par_f0_valid got %b want 1", valid); end
    checks++; if (code !== 8'hF0) begin errors++; $display("FAIL par_f0_code got %h want f0", code); end
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL par_f0_ferr got %0d want 1", ferr_cnt - f0); end
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL par_pop got %b want 0", valid); end
  endtask

  task automatic test_timeout;
    int f0;
    f0 = ferr_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (7000) @(negedge clk);
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL to_early got %0d want 0", ferr_cnt - f0); end
    repeat (2000) @(negedge clk);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL to_ferr got %0d want 1", ferr_cnt - f0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL to_valid got %b want 0", valid); end
    send_frame(8'h5A, 1'b1, 1'b1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL to_5a_valid got %b want 1", valid); end
    checks++; if (code !== 8'h5A) begin errors++; $display("FAIL to_5a_code got %h want 5a", code); end
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL to_5a_ferr got %0d want 1", ferr_cnt - f0); end
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
  endtask

  task automatic test_glitch;
    logic [7:0] d;
    int f0;
    d  = 8'hA5;
    f0 = ferr_cnt;
    // Data held low so any spurious fall would start a frame
    @(negedge clk); ps2_data = 1'b0; ps2_clk = 1'b0;
    repeat (3) @(negedge clk); ps2_clk = 1'b1;
    repeat (30) @(negedge clk); ps2_clk = 1'b0;
    repeat (7) @(negedge clk); ps2_clk = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL gl_ferr got %0d want 0", ferr_cnt - f0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL gl_valid got %b want 0", valid); end
    // 8-cycle low is a real fall: acts as the start bit
    ps2_clk = 1'b0;
    repeat (8) @(negedge clk); ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    repeat (20) @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL gl_a5_valid got %b want 1", valid); end
    checks++; if (code !== 8'hA5) begin errors++; $display("FAIL gl_a5_code got %h want a5", code); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL gl_a5_ferr got %0d want 0", ferr_cnt - f0); end
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
  endtask

  task automatic test_overflow;
    logic [7:0] bytes [5];
    logic       pars  [5];
    logic [7:0] d;
    int o0;
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    pars  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    o0 = ovf_cnt;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_frame(bytes[i], pars[i], 1'b1);
      if (i == 3) begin
        checks++; if (ovf_cnt - o0 !== 0) begin errors++; $display("FAIL ovf_at4 got %0d want 0", ovf_cnt - o0); end
      end
    end
    checks++; if (ovf_cnt - o0 !== 1) begin errors++; $display("FAIL ovf_at5 got %0d want 1", ovf_cnt - o0); end
    @(negedge clk);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid%0d got %b want 1", i, valid); end
      checks++; if (code !== bytes[i]) begin errors++; $display("FAIL ovf_drain_code%0d got %h want %h", i, code, bytes[i]); end
      @(posedge clk); #1;
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_empty got %b want 0", valid); end
    @(negedge clk); ready = 1'b0;

    // Refill, then pop exactly on the push cycle of a fifth frame
    for (int i = 0; i < 4; i++) send_frame(bytes[i], pars[i], 1'b1);
    o0 = ovf_cnt;
    d  = 8'h05;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(1'b1);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk); ready = 1'b1;
    @(posedge clk); #1; ready = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (ovf_cnt - o0 !== 0) begin errors++; $display("FAIL simul_ovf got %0d want 0", ovf_cnt - o0); end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL simul_valid%0d got %b want 1", i, valid); end
      checks++; if (code !== bytes[i+1]) begin errors++; $display("FAIL simul_code%0d got %h want %h", i, code, bytes[i+1]); end
      @(posedge clk); #1;
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL simul_empty got %b want 0", valid); end
    @(negedge clk); ready = 1'b0;
  endtask

  task automatic test_reset_midframe;
    int f0;
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mr_queued got %b want 1", valid); end
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b want 0", valid); end
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL mr_code got %h want 00", code); end
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mr_post_valid got %b want 0", valid); end
    f0 = ferr_cnt;
    send_frame(8'h29, 1'b0, 1'b1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mr_29_valid got %b want 1", valid); end
    checks++; if (code !== 8'h29) begin errors++; $display("FAIL mr_29_code got %h want 29", code); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL mr_ferr got %0d want 0", ferr_cnt - f0); end
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mr_pop got %b want 0", valid); end
  endtask

  task automatic test_pulse_width;
    checks++; if (long_cnt !== 0) begin errors++; $display("FAIL pulse_width got %0d want 0", long_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_timeout();
    test_glitch();
    test_overflow();
    test_reset_midframe();
    test_pulse_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
